serial_frame_tx: RTL and testbench

Parallel-in, serial-out framed transmitter. It generates the single-bit serial data stream that the team's D flip-flop and latch capture chains sample on clk. A WIDTH-bit word is accepted through a valid/ready handshake and shifted out as start bit, data bits, then stop bit. True and complement outputs are provided, mirroring the Q/_Q pair of the storage elements.

---
 rtl/serial_frame_pkg.sv | 15 +
 rtl/tx_bit_counter.sv | 32 +++
 rtl/serial_frame_tx.sv | 97 +++++++++
 tb/tb_serial_frame_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the framed serial transmitter.
// The state type and the two fixed sout levels used by serial_frame_tx.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic SOUT_IDLE  = 1'b1;
  localparam logic SOUT_START = 1'b0;

endpackage

// File: rtl/tx_bit_counter.sv
// Data-bit counter for serial_frame_tx.
// Flags the last data bit of a frame; sized to $clog2(WIDTH) bits.
module tx_bit_counter
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits, stop bit.
// Accepts a word on a valid/ready handshake; drives registered sout and its complement.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_n,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic             sout_q;
  logic             done_q;
  logic             last;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  assign load_ready = (state == IDLE);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);
  assign sout       = sout_q;
  assign sout_n     = ~sout_q;
  assign done       = done_q;

  // Counter sits at zero outside DATA, so it is already cleared on entry.
  tx_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != DATA),
    .enable((state == DATA) && !last),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      sout_q <= SOUT_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= START;
            sr     <= din;
            sout_q <= SOUT_START;
          end
        end
        START: begin
          state  <= DATA;
          sout_q <= head_bit(sr);
          sr     <= shift_out(sr);
        end
        DATA: begin
          // sout is registered one bit ahead: the last data bit is already on the line.
          if (last) begin
            state  <= STOP;
            sout_q <= SOUT_IDLE;
          end else begin
            sout_q <= head_bit(sr);
            sr     <= shift_out(sr);
          end
        end
        STOP: begin
          state  <= IDLE;
          sout_q <= SOUT_IDLE;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          sout_q <= SOUT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: LSB-first and MSB-first instances share stimulus.
// A frame-level model predicts every output each cycle; literal vectors pin the model.
module tb_serial_frame_tx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic [1:0]       load_ready;
  logic [1:0]       sout;
  logic [1:0]       sout_n;
  logic [1:0]       busy;
  logic [1:0]       done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_frame_tx #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready[0]), .sout(sout[0]), .sout_n(sout_n[0]),
    .busy(busy[0]), .done(done[0])
  );

  serial_frame_tx #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready[1]), .sout(sout[1]), .sout_n(sout_n[1]),
    .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %b, want %b", nm, idx, $time, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // Frame model: position within the frame (-1 = idle), captured word, done flag.
  int               phase  [2] = '{-1, -1};
  logic [WIDTH-1:0] word   [2];
  logic             done_m [2] = '{1'b0, 1'b0};

  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int p, input bit lsb);
    if (p == 0) return 1'b0;
    if (p > WIDTH) return 1'b1;
    return lsb ? w[p-1] : w[WIDTH-p];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i]  <= -1;
        done_m[i] <= 1'b0;
      end else if (phase[i] < 0) begin
        done_m[i] <= 1'b0;
        if (load_valid) begin
          phase[i] <= 0;
          word[i]  <= din;
        end
      end else if (phase[i] == WIDTH + 1) begin
        phase[i]  <= -1;
        done_m[i] <= 1'b1;
      end else begin
        phase[i] <= phase[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic es;
      es = (phase[i] < 0) ? 1'b1 : frame_bit(word[i], phase[i], (i == 0));
      chk1("sout", i, sout[i], es);
      chk1("sout_n", i, sout_n[i], ~es);
      chk1("busy", i, busy[i], phase[i] >= 0);
      chk1("load_ready", i, load_ready[i], phase[i] < 0);
      chk1("done", i, done[i], (phase[i] < 0) && done_m[i]);
    end
  end

  // Handshake one word, capture the 10 frame cycles, optionally poke load_valid mid-frame.
  task automatic send(input logic [WIDTH-1:0] d, input logic [9:0] exp_l,
                      input logic [9:0] exp_m, input int poke, input string tag);
    logic [9:0] gl, gm, gb;
    logic       gd;
    gd = 1'b0;
    @(posedge clk); #1;
    din = d;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gl[9-k] = sout[0];
      gm[9-k] = sout[1];
      gb[9-k] = busy[0] & busy[1];
      gd      = gd | done[0] | done[1];
      if (k == poke) begin
        din = 8'hFF;
        load_valid = 1'b1;
      end else if (k == poke + 1) begin
        load_valid = 1'b0;
      end
    end
    @(negedge clk);
    chkv({tag, "_lsb_bits"}, 16'(gl), 16'(exp_l));
    chkv({tag, "_msb_bits"}, 16'(gm), 16'(exp_m));
    chkv({tag, "_busy"}, 16'(gb), 16'h03FF);
    chkv({tag, "_done_in_frame"}, 16'(gd), 16'h0000);
    chkv({tag, "_done_after"}, 16'(done), 16'h0003);
  endtask

  initial begin
    int starts[2];
    int n_start, n_done;
    logic pb;

    rst = 1'b1;
    din = '0;
    load_valid = 1'b0;
    #12;
    chkv("reset_outputs", {6'b0, sout, sout_n, load_ready, busy, done}, {6'b0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkv("post_reset_outputs", {6'b0, sout, sout_n, load_ready, busy, done}, {6'b0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00});

    // Single frames, both bit orders.
    send(8'hC1, 10'b0100000111, 10'b0110000011, -10, "c1");
    send(8'h5A, 10'b0010110101, 10'b0010110101, -10, "5a");
    send(8'h80, 10'b0000000011, 10'b0100000001, -10, "80");

    // Busy ignore: load_valid pulsed with 0xFF during DATA.
    send(8'h3C, 10'b0001111001, 10'b0001111001, 4, "ignore");
    repeat (3) @(negedge clk);
    chkv("ignore_no_extra_frame", 16'(busy), 16'h0000);

    // Back-to-back with load_valid held high.
    @(posedge clk); #1;
    din = 8'hC1;
    load_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h3C;
    n_start = 0;
    n_done = 0;
    pb = 1'b0;
    starts = '{-1, -1};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy[0] && !pb) begin
        if (n_start < 2) starts[n_start] = c;
        n_start++;
        if (n_start == 2) load_valid = 1'b0;
      end
      pb = busy[0];
      if (done[0]) n_done++;
    end
    load_valid = 1'b0;
    chkv("b2b_first_start", 16'(starts[0]), 16'd1);
    chkv("b2b_start_spacing", 16'(starts[1] - starts[0]), 16'd11);
    chkv("b2b_frames", 16'(n_start), 16'd2);
    chkv("b2b_done_pulses", 16'(n_done), 16'd2);

    // Reset in the 3rd data bit, with a load attempted while rst is high.
    @(posedge clk); #1;
    din = 8'hA7;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chkv("midframe_busy_before_rst", 16'(busy), 16'h0003);
    rst = 1'b1;
    din = 8'h55;
    load_valid = 1'b1;
    #1;
    chkv("midframe_rst_outputs", {6'b0, sout, sout_n, load_ready, busy, done}, {6'b0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    load_valid = 1'b0;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done != 2'b00 || busy != 2'b00) n_done++;
    end
    chkv("midframe_no_done_or_frame", 16'(n_done), 16'd0);
    send(8'h01, 10'b0100000001, 10'b0000000011, -10, "after_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
